// File: rtl/vip_conv2d_1_filter1_feed_ctrl.sv
// ---------------------------------------------------------------------------
// vip_conv2d_1_filter1_feed_ctrl
//
// Purpose:
//   Sequencer that turns one channel-interleaved upstream word stream into
//   8-lane pixel vectors for the conv2d_1 filter1 datapath. Words are popped
//   from a show-ahead source FIFO in channel order 0..7, collected in eight
//   lane registers, and then written into the eight per-channel input FIFOs
//   with a single shared write strobe. A frame is exactly NUM_PIXELS vectors,
//   after which a one-cycle done pulse is produced.
//
// Ports:
//   clock          in   system clock, all logic on the rising edge
//   reset          in   synchronous, active-high reset
//   start          in   one-cycle frame start pulse (only honoured when idle)
//   src_data       in   head word of the upstream FIFO (show-ahead)
//   src_empty      in   upstream FIFO empty
//   src_rdreq      out  pop the upstream head word
//   fifo_in_data0..7 out  lane registers for channels 0..7
//   fifo_in_wrreq  out  write strobe shared by all eight input FIFOs
//   fifo_in_full   in   datapath input FIFOs full
//   busy           out  frame in progress (high in every non-idle state)
//   done           out  one-cycle pulse at frame end
//   pixel_count    out  vectors written in the current or last frame
// ---------------------------------------------------------------------------
module vip_conv2d_1_filter1_feed_ctrl #(
    parameter int DWIDTH     = 32,
    parameter int NUM_PIXELS = 12544,
    parameter int CNT_WIDTH  = 14
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [DWIDTH-1:0]    src_data,
    input  logic                 src_empty,
    output logic                 src_rdreq,
    output logic [DWIDTH-1:0]    fifo_in_data0,
    output logic [DWIDTH-1:0]    fifo_in_data1,
    output logic [DWIDTH-1:0]    fifo_in_data2,
    output logic [DWIDTH-1:0]    fifo_in_data3,
    output logic [DWIDTH-1:0]    fifo_in_data4,
    output logic [DWIDTH-1:0]    fifo_in_data5,
    output logic [DWIDTH-1:0]    fifo_in_data6,
    output logic [DWIDTH-1:0]    fifo_in_data7,
    output logic                 fifo_in_wrreq,
    input  logic                 fifo_in_full,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] pixel_count
);

    // Value of the pixel counter while the last vector of a frame is issued.
    localparam logic [CNT_WIDTH-1:0] LAST_PIXEL = CNT_WIDTH'(NUM_PIXELS - 1);
    localparam logic [2:0]           LAST_LANE  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GATHER,
        ST_ISSUE,
        ST_DONE
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [2:0]            lane_idx_q;
    logic [2:0]            lane_idx_d;
    logic [CNT_WIDTH-1:0]  pixel_count_q;
    logic [CNT_WIDTH-1:0]  pixel_count_d;
    logic [DWIDTH-1:0]     lane_q [8];

    // Internal pop / write decisions before the reset qualification.
    logic                  pop;
    logic                  issue;

    // Next-state and handshake logic. A pop happens whenever the source has
    // data while gathering; the eighth pop of a vector moves on to ISSUE.
    // In ISSUE the vector is written as soon as the input FIFOs have room,
    // and the counter value before the increment decides whether this was
    // the final vector of the frame.
    always_comb begin
        state_d       = state_q;
        lane_idx_d    = lane_idx_q;
        pixel_count_d = pixel_count_q;
        pop           = 1'b0;
        issue         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d       = ST_GATHER;
                    lane_idx_d    = 3'd0;
                    pixel_count_d = '0;
                end
            end

            ST_GATHER: begin
                pop = ~src_empty;
                if (pop) begin
                    if (lane_idx_q == LAST_LANE) begin
                        lane_idx_d = 3'd0;
                        state_d    = ST_ISSUE;
                    end else begin
                        lane_idx_d = lane_idx_q + 3'd1;
                    end
                end
            end

            ST_ISSUE: begin
                issue = ~fifo_in_full;
                if (issue) begin
                    pixel_count_d = pixel_count_q + CNT_WIDTH'(1);
                    if (pixel_count_q == LAST_PIXEL) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_GATHER;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state register. Reset drops any partially gathered vector;
    // words already taken from the source are simply lost.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            lane_idx_q    <= 3'd0;
            pixel_count_q <= '0;
        end else begin
            state_q       <= state_d;
            lane_idx_q    <= lane_idx_d;
            pixel_count_q <= pixel_count_d;
        end
    end

    // Lane registers only ever load on a pop, which keeps the outputs
    // steady for the whole ISSUE phase regardless of how long full stalls.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < 8; k++) begin
                lane_q[k] <= '0;
            end
        end else if (pop) begin
            lane_q[lane_idx_q] <= src_data;
        end
    end

    // Handshakes are suppressed while reset is asserted so that no word is
    // popped or written in a cycle whose state update is being discarded.
    always_comb begin
        src_rdreq     = pop & ~reset;
        fifo_in_wrreq = issue & ~reset;
        busy          = (state_q != ST_IDLE);
        done          = (state_q == ST_DONE);
        pixel_count   = pixel_count_q;
    end

    // Lane register fan-out to the per-channel FIFO data ports.
    always_comb begin
        fifo_in_data0 = lane_q[0];
        fifo_in_data1 = lane_q[1];
        fifo_in_data2 = lane_q[2];
        fifo_in_data3 = lane_q[3];
        fifo_in_data4 = lane_q[4];
        fifo_in_data5 = lane_q[5];
        fifo_in_data6 = lane_q[6];
        fifo_in_data7 = lane_q[7];
    end

endmodule

// File: tb/tb_vip_conv2d_1_filter1_feed_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vip_conv2d_1_filter1_feed_ctrl
//
// Purpose:
//   Self-checking bench for the conv2d_1 filter1 feed controller, built with
//   a four-vector frame. The upstream FIFO is a queue; a second queue holds
//   every word pushed since the last flush, and each written vector must be
//   the next eight of those words in push order.
// ---------------------------------------------------------------------------
module tb_vip_conv2d_1_filter1_feed_ctrl;

    localparam int DW   = 32;
    localparam int NPIX = 4;
    localparam int CW   = 14;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [DW-1:0] src_data;
    logic          src_empty;
    logic          src_rdreq;
    logic [DW-1:0] fifo_in_data0, fifo_in_data1, fifo_in_data2, fifo_in_data3;
    logic [DW-1:0] fifo_in_data4, fifo_in_data5, fifo_in_data6, fifo_in_data7;
    logic          fifo_in_wrreq;
    logic          fifo_in_full;
    logic          busy;
    logic          done;
    logic [CW-1:0] pixel_count;

    logic [DW-1:0] laneOut [8];

    int testsRun    = 0;
    int testsFailed = 0;

    logic [DW-1:0] srcQ[$];
    logic [DW-1:0] modelQ[$];
    bit            forceEmpty = 1'b0;

    bit            curRd, curWr, curDone, curBusy, curEmpty;
    int            pops       = 0;
    int            writes     = 0;
    int            donePulses = 0;
    logic [DW-1:0] lastVec [8];

    always #5 clock = ~clock;

    assign laneOut[0] = fifo_in_data0;
    assign laneOut[1] = fifo_in_data1;
    assign laneOut[2] = fifo_in_data2;
    assign laneOut[3] = fifo_in_data3;
    assign laneOut[4] = fifo_in_data4;
    assign laneOut[5] = fifo_in_data5;
    assign laneOut[6] = fifo_in_data6;
    assign laneOut[7] = fifo_in_data7;

    vip_conv2d_1_filter1_feed_ctrl #(
        .DWIDTH     (DW),
        .NUM_PIXELS (NPIX),
        .CNT_WIDTH  (CW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .src_data      (src_data),
        .src_empty     (src_empty),
        .src_rdreq     (src_rdreq),
        .fifo_in_data0 (fifo_in_data0),
        .fifo_in_data1 (fifo_in_data1),
        .fifo_in_data2 (fifo_in_data2),
        .fifo_in_data3 (fifo_in_data3),
        .fifo_in_data4 (fifo_in_data4),
        .fifo_in_data5 (fifo_in_data5),
        .fifo_in_data6 (fifo_in_data6),
        .fifo_in_data7 (fifo_in_data7),
        .fifo_in_wrreq (fifo_in_wrreq),
        .fifo_in_full  (fifo_in_full),
        .busy          (busy),
        .done          (done),
        .pixel_count   (pixel_count)
    );

    // Show-ahead source FIFO view of the queue.
    task automatic refresh();
        src_empty = forceEmpty || (srcQ.size() == 0);
        src_data  = (srcQ.size() != 0) ? srcQ[0] : '0;
    endtask

    task automatic pushWord(input logic [DW-1:0] w);
        srcQ.push_back(w);
        modelQ.push_back(w);
        refresh();
    endtask

    // One clock cycle: sample the handshakes mid-cycle, let the edge happen,
    // then apply the pop to the source queue.
    task automatic tick();
        logic [DW-1:0] junk;
        #1;
        curRd    = src_rdreq;
        curWr    = fifo_in_wrreq;
        curDone  = done;
        curBusy  = busy;
        curEmpty = src_empty;
        if (curWr) begin
            for (int k = 0; k < 8; k++) lastVec[k] = laneOut[k];
        end
        @(posedge clock);
        #1;
        if (curRd && srcQ.size() != 0) junk = srcQ.pop_front();
        if (curRd)   pops++;
        if (curWr)   writes++;
        if (curDone) donePulses++;
        refresh();
    endtask

    task automatic runUntilWrite(input int maxTicks, output int waited, output bit got);
        got    = 1'b0;
        waited = 0;
        while (!got && waited < maxTicks) begin
            tick();
            waited++;
            got = curWr;
        end
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        start        = 1'b0;
        fifo_in_full = 1'b0;
        forceEmpty   = 1'b0;
        refresh();
        tick();
        tick();
        reset = 1'b0;
        #1;
        testsRun++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_status busy=%b done=%b expected 0 0", busy, done);
        end
        testsRun++;
        if (pixel_count !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_count got %0d expected 0", pixel_count);
        end
        testsRun++;
        if (src_rdreq !== 1'b0 || fifo_in_wrreq !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_strobes rdreq=%b wrreq=%b expected 0 0", src_rdreq, fifo_in_wrreq);
        end
        for (int k = 0; k < 8; k++) begin
            testsRun++;
            if (laneOut[k] !== '0) begin
                testsFailed++;
                $display("[TB] FAIL reset_lane%0d got %h expected 0", k, laneOut[k]);
            end
        end
        pops = 0; writes = 0; donePulses = 0;
    endtask

    task automatic test_single_vector();
        int p0, rdRun, maxRun, firstWr;
        logic [DW-1:0] e;
        bit bad;
        for (int k = 0; k < 8; k++) pushWord(DW'(k));
        p0 = pops; rdRun = 0; maxRun = 0; firstWr = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
        testsRun++;
        if (busy !== 1'b1 || pixel_count !== '0) begin
            testsFailed++;
            $display("[TB] FAIL start_accept busy=%b count=%0d expected 1 0", busy, pixel_count);
        end
        for (int t = 1; t <= 20 && firstWr < 0; t++) begin
            tick();
            if (curRd) rdRun++; else rdRun = 0;
            if (rdRun > maxRun) maxRun = rdRun;
            if (curWr) firstWr = t;
        end
        testsRun++;
        if (firstWr != 9) begin
            testsFailed++;
            $display("[TB] FAIL first_write_latency got %0d expected 9", firstWr);
        end
        testsRun++;
        if (pops - p0 != 8 || maxRun != 8) begin
            testsFailed++;
            $display("[TB] FAIL first_pops got %0d run %0d expected 8 8", pops - p0, maxRun);
        end
        bad = 1'b0;
        for (int k = 0; k < 8; k++) begin
            e = modelQ.pop_front();
            if (firstWr < 0 || lastVec[k] !== e) bad = 1'b1;
        end
        testsRun++;
        if (bad) begin
            testsFailed++;
            $display("[TB] FAIL first_vector lane0=%h lane7=%h expected 0 7", lastVec[0], lastVec[7]);
        end
        testsRun++;
        if (pixel_count !== CW'(1)) begin
            testsFailed++;
            $display("[TB] FAIL first_count got %0d expected 1", pixel_count);
        end
    endtask

    task automatic test_empty_gap();
        int p0, waited;
        bit rdSeen, got, bad;
        logic [DW-1:0] e;
        for (int k = 0; k < 8; k++) pushWord($urandom);
        p0 = pops;
        repeat (3) tick();
        testsRun++;
        if (pops - p0 != 3) begin
            testsFailed++;
            $display("[TB] FAIL gap_first_pops got %0d expected 3", pops - p0);
        end
        forceEmpty = 1'b1;
        refresh();
        p0 = pops; rdSeen = 1'b0;
        repeat (5) begin
            tick();
            if (curRd) rdSeen = 1'b1;
        end
        testsRun++;
        if (rdSeen || pops != p0) begin
            testsFailed++;
            $display("[TB] FAIL gap_no_pop rdreq_seen=%b pops=%0d expected 0 0", rdSeen, pops - p0);
        end
        forceEmpty = 1'b0;
        refresh();
        runUntilWrite(20, waited, got);
        testsRun++;
        if (!got || waited != 6) begin
            testsFailed++;
            $display("[TB] FAIL gap_resume got=%b cycles %0d expected 1 6", got, waited);
        end
        bad = 1'b0;
        for (int k = 0; k < 8; k++) begin
            e = modelQ.pop_front();
            if (!got || lastVec[k] !== e) bad = 1'b1;
        end
        testsRun++;
        if (bad) begin
            testsFailed++;
            $display("[TB] FAIL gap_vector lane3=%h lane7=%h", lastVec[3], lastVec[7]);
        end
        testsRun++;
        if (pixel_count !== CW'(2)) begin
            testsFailed++;
            $display("[TB] FAIL gap_count got %0d expected 2", pixel_count);
        end
    endtask

    task automatic test_full_stall();
        int p0;
        bit wrSeen, unstable, bad;
        logic [DW-1:0] e;
        fifo_in_full = 1'b1;
        for (int k = 0; k < 8; k++) pushWord($urandom);
        p0 = pops;
        repeat (8) tick();
        testsRun++;
        if (pops - p0 != 8) begin
            testsFailed++;
            $display("[TB] FAIL stall_gather pops %0d expected 8", pops - p0);
        end
        // Words for the next vector sit in the source during the stall.
        for (int k = 0; k < 8; k++) pushWord($urandom);
        p0 = pops; wrSeen = 1'b0; unstable = 1'b0;
        repeat (20) begin
            tick();
            if (curWr) wrSeen = 1'b1;
            for (int k = 0; k < 8; k++) if (laneOut[k] !== modelQ[k]) unstable = 1'b1;
        end
        testsRun++;
        if (wrSeen || pops != p0) begin
            testsFailed++;
            $display("[TB] FAIL stall_hold wrreq_seen=%b pops=%0d expected 0 0", wrSeen, pops - p0);
        end
        testsRun++;
        if (unstable) begin
            testsFailed++;
            $display("[TB] FAIL stall_lanes lane0=%h expected %h", laneOut[0], modelQ[0]);
        end
        fifo_in_full = 1'b0;
        tick();
        testsRun++;
        if (curWr !== 1'b1 || curRd !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL stall_release wrreq=%b rdreq=%b expected 1 0", curWr, curRd);
        end
        bad = 1'b0;
        for (int k = 0; k < 8; k++) begin
            e = modelQ.pop_front();
            if (lastVec[k] !== e) bad = 1'b1;
        end
        testsRun++;
        if (bad) begin
            testsFailed++;
            $display("[TB] FAIL stall_vector lane0=%h", lastVec[0]);
        end
        testsRun++;
        if (pixel_count !== CW'(3)) begin
            testsFailed++;
            $display("[TB] FAIL stall_count got %0d expected 3", pixel_count);
        end
    endtask

    task automatic test_frame_end();
        int w0, d0, wrTick, doneTick;
        bit bad;
        logic [DW-1:0] e;
        w0 = writes; d0 = donePulses; wrTick = -1; doneTick = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (curWr) wrTick = 0;
        for (int t = 1; t <= 40 && doneTick < 0; t++) begin
            tick();
            if (curWr) wrTick = t;
            if (curDone) begin
                doneTick = t;
                testsRun++;
                if (curBusy !== 1'b1) begin
                    testsFailed++;
                    $display("[TB] FAIL done_busy got %b expected 1", curBusy);
                end
            end
        end
        testsRun++;
        if (doneTick < 0 || doneTick != wrTick + 1) begin
            testsFailed++;
            $display("[TB] FAIL done_timing done at %0d last write at %0d", doneTick, wrTick);
        end
        testsRun++;
        if (writes - w0 != 1 || donePulses - d0 != 1) begin
            testsFailed++;
            $display("[TB] FAIL frame_writes writes %0d dones %0d expected 1 1", writes - w0, donePulses - d0);
        end
        bad = 1'b0;
        for (int k = 0; k < 8; k++) begin
            e = modelQ.pop_front();
            if (lastVec[k] !== e) bad = 1'b1;
        end
        testsRun++;
        if (bad) begin
            testsFailed++;
            $display("[TB] FAIL last_vector lane0=%h", lastVec[0]);
        end
        tick();
        testsRun++;
        if (curBusy !== 1'b0 || curDone !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL after_done busy=%b done=%b expected 0 0", curBusy, curDone);
        end
        testsRun++;
        if (pixel_count !== CW'(NPIX)) begin
            testsFailed++;
            $display("[TB] FAIL frame_count got %0d expected %0d", pixel_count, NPIX);
        end
    endtask

    task automatic test_restart_random();
        int p0, waited, fw, d0;
        bit got, bad, badCnt, badHs;
        logic [DW-1:0] e;
        for (int k = 0; k < 8; k++) pushWord($urandom);
        p0 = pops;
        repeat (3) tick();
        testsRun++;
        if (pops != p0 || pixel_count !== CW'(NPIX)) begin
            testsFailed++;
            $display("[TB] FAIL idle_hold pops=%0d count=%0d expected 0 %0d", pops - p0, pixel_count, NPIX);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        testsRun++;
        if (pixel_count !== '0) begin
            testsFailed++;
            $display("[TB] FAIL restart_count got %0d expected 0", pixel_count);
        end
        runUntilWrite(20, waited, got);
        bad = 1'b0;
        for (int k = 0; k < 8; k++) begin
            e = modelQ.pop_front();
            if (!got || lastVec[k] !== e) bad = 1'b1;
        end
        testsRun++;
        if (bad || pixel_count !== CW'(1)) begin
            testsFailed++;
            $display("[TB] FAIL restart_vector got=%b count=%0d lane0=%h", got, pixel_count, lastVec[0]);
        end
        // Rest of the frame under random source gaps and back-pressure.
        for (int k = 0; k < 8 * (NPIX - 1); k++) pushWord($urandom);
        fw = 1; d0 = donePulses; bad = 1'b0; badCnt = 1'b0; badHs = 1'b0;
        for (int t = 0; t < 1500 && donePulses == d0; t++) begin
            forceEmpty   = ($urandom_range(0, 3) == 0);
            fifo_in_full = ($urandom_range(0, 2) == 0);
            refresh();
            tick();
            if ((curRd && curWr) || (curRd && curEmpty)) badHs = 1'b1;
            if (curWr) begin
                fw++;
                for (int k = 0; k < 8; k++) begin
                    e = modelQ.pop_front();
                    if (lastVec[k] !== e) bad = 1'b1;
                end
                if (pixel_count !== CW'(fw)) badCnt = 1'b1;
            end
        end
        forceEmpty   = 1'b0;
        fifo_in_full = 1'b0;
        refresh();
        testsRun++;
        if (bad) begin
            testsFailed++;
            $display("[TB] FAIL random_vectors lane data differs from stream order");
        end
        testsRun++;
        if (badCnt || badHs) begin
            testsFailed++;
            $display("[TB] FAIL random_protocol count_err=%b handshake_err=%b expected 0 0", badCnt, badHs);
        end
        testsRun++;
        if (donePulses - d0 != 1 || fw != NPIX) begin
            testsFailed++;
            $display("[TB] FAIL random_frame dones %0d writes %0d expected 1 %0d", donePulses - d0, fw, NPIX);
        end
    endtask

    task automatic test_reset_mid();
        int waited;
        bit got, bad, laneBad;
        logic [DW-1:0] e;
        tick();
        for (int k = 0; k < 8; k++) pushWord($urandom);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        laneBad = 1'b0;
        for (int k = 0; k < 8; k++) if (laneOut[k] !== '0) laneBad = 1'b1;
        testsRun++;
        if (busy !== 1'b0 || pixel_count !== '0 || laneBad || src_rdreq !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL mid_reset busy=%b count=%0d lanes_nonzero=%b rdreq=%b expected 0 0 0 0",
                     busy, pixel_count, laneBad, src_rdreq);
        end
        srcQ.delete();
        modelQ.delete();
        refresh();
        for (int k = 0; k < 8; k++) pushWord($urandom);
        start = 1'b1;
        tick();
        start = 1'b0;
        runUntilWrite(20, waited, got);
        bad = 1'b0;
        for (int k = 0; k < 8; k++) begin
            e = modelQ.pop_front();
            if (!got || lastVec[k] !== e) bad = 1'b1;
        end
        testsRun++;
        if (bad || waited != 9) begin
            testsFailed++;
            $display("[TB] FAIL post_reset_vector got=%b cycles=%0d lane0=%h expected 1 9",
                     got, waited, lastVec[0]);
        end
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        fifo_in_full = 1'b0;
        refresh();
        test_reset();
        test_single_vector();
        test_empty_gap();
        test_full_stall();
        test_frame_end();
        test_restart_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/vip_conv2d_1_filter1_feed_ctrl.md
Name: vip_conv2d_1_filter1_feed_ctrl

Overview:
- Sequencer feeding the 8-channel conv2d_1 filter1 datapath from one channel-interleaved upstream stream.
- Pops 32-bit words from a show-ahead source FIFO in channel order 0..7 and assembles them into an 8-lane pixel vector.
- Issues one write into the eight per-channel input FIFOs, respecting their full flag, and counts NUM_PIXELS vectors per frame.
- Signals frame completion.

Parameters:
- DWIDTH, 32, width of one channel word.
- NUM_PIXELS, 12544, pixel vectors per frame (112x112).
- CNT_WIDTH, 14, pixel counter width; must satisfy 2^CNT_WIDTH >= NUM_PIXELS.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE.
- src_data  in  DWIDTH  head word of the upstream FIFO (show-ahead); valid while src_empty=0.
- src_empty  in  1  upstream FIFO empty.
- src_rdreq  out  1  pop upstream head word.
- fifo_in_data0..fifo_in_data7  out  DWIDTH each  channel 0..7 lane registers toward the datapath input FIFOs.
- fifo_in_wrreq  out  1  write strobe to all eight input FIFOs.
- fifo_in_full  in  1  datapath input FIFOs full.
- busy  out  1  high from the cycle after an accepted start until the cycle DONE is left.
- done  out  1  one-cycle pulse at frame end.
- pixel_count  out  CNT_WIDTH  number of vectors written in the current or last frame.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; lane_idx=0; pixel_count=0; lane registers 0; busy=0, done=0; src_rdreq=0, fifo_in_wrreq=0.
  - Reset mid-frame discards any partial vector.
  - Words already popped from the source are lost; no recovery is attempted.
- States:
  - IDLE: start=1 -> GATHER; lane_idx=0, pixel_count=0.
  - GATHER: src_rdreq = ~src_empty (combinational).
    - When src_rdreq=1, lane[lane_idx] <= src_data and lane_idx++.
    - If lane_idx==7 on that pop: lane_idx <= 0 and go to ISSUE.
    - src_empty=1 stalls with no capture and no index change, for any number of cycles.
  - ISSUE: src_rdreq=0; fifo_in_wrreq = ~fifo_in_full (combinational).
    - On wrreq=1: pixel_count++; if pixel_count == NUM_PIXELS-1 before the increment, go to DONE, else go to GATHER.
    - fifo_in_full=1 holds ISSUE with lane registers stable, for any duration.
  - DONE: done=1 for exactly this one cycle, busy=1 -> IDLE. pixel_count retains NUM_PIXELS.
- busy = (state != IDLE).
- start asserted outside IDLE is ignored and is not queued.
- Lane registers change only on capture in GATHER, so fifo_in_data* is stable throughout ISSUE.
- Throughput: 8 pop cycles + 1 issue cycle = 9 cycles per vector minimum.
- First wrreq occurs no earlier than 9 cycles after start is sampled (1 cycle to leave IDLE, 8 pops), given a non-empty source.
- Word-to-channel mapping: the k-th word popped within a vector goes to fifo_in_data[k].
  - Channel 0 is the first word after start and after each issue.
- Counters wrap nowhere: the frame ends exactly at NUM_PIXELS vectors.
- A src_empty/fifo_in_full toggle in the same cycle as a transition is evaluated using that cycle's sampled value only; there is no look-ahead.

Test Plan:
- Reset then start with source preloaded with 0x0..0x7 and fifo_in_full=0 -> src_rdreq high 8 consecutive cycles; fifo_in_wrreq high 1 cycle with fifo_in_data0..7 = 0x0..0x7; pixel_count=1.
- Source empty for 5 cycles after 3 words -> no capture while empty; the vector completes after the remaining 5 words with lanes 3..7 correct; src_rdreq=0 during the gap.
- fifo_in_full held high 20 cycles in ISSUE -> no wrreq and lanes stable; a single wrreq on the first cycle full=0; no extra pops during the stall.
- NUM_PIXELS=4 override with 32 words streamed -> exactly 4 wrreq pulses; done pulses once in the cycle after the 4th wrreq; busy drops the next cycle; pixel_count=4.
- start pulsed mid-frame -> ignored; a second start after done -> pixel_count resets to 0 and a new frame runs.
- Reset asserted after 5 words of a vector -> next cycle state IDLE, outputs zeroed; a new start begins at channel 0 with no residue from the old vector.
